// File: rtl/ffs_result_queue.sv
// Result queue behind the findfirstset pipeline: buffers emitted indices in a
// first-word-fall-through FIFO and grants upstream issue credit so that results emerge into free slots.
module ffs_result_queue #(
  parameter  int unsigned WIDTH = 10,
  parameter  int unsigned DEPTH = 16,
  parameter  int unsigned LAT   = 10,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = PW + 1,
  localparam int unsigned FW    = $clog2(LAT + 1) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue,
  input  logic             res_valid,
  input  logic [WIDTH-1:0] res_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             can_issue,
  output logic [CW-1:0]    count,
  output logic [FW-1:0]    in_flight,
  output logic             overflow,
  output logic             protocol_err,
  output logic [7:0]       drop_count
);

  localparam int unsigned SW = ((CW > FW) ? CW : FW) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [FW-1:0]    in_flight_q, in_flight_d;
  logic             out_valid_q, out_valid_d;
  logic             overflow_q, overflow_d;
  logic             protocol_err_q, protocol_err_d;
  logic [7:0]       drop_count_q, drop_count_d;

  logic pop, push, drop, full, unexpected;

  // Next-state for pointers, occupancy, credit tracking and sticky status
  always_comb begin
    full       = (count_q == CW'(DEPTH));
    pop        = out_valid_q & out_ready;
    push       = res_valid & (~full | pop);
    drop       = res_valid & full & ~pop;
    unexpected = res_valid & ~issue & (in_flight_q == '0);

    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    out_valid_d = (count_d != '0);

    in_flight_d = in_flight_q;
    if (issue && !res_valid) begin
      if (in_flight_q != {FW{1'b1}}) in_flight_d = in_flight_q + FW'(1);
    end else if (res_valid && !issue) begin
      if (in_flight_q != '0) in_flight_d = in_flight_q - FW'(1);
    end

    overflow_d     = overflow_q | drop;
    protocol_err_d = protocol_err_q | unexpected;
    drop_count_d   = drop_count_q;
    if (drop && drop_count_q != 8'hFF) drop_count_d = drop_count_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      in_flight_q    <= '0;
      out_valid_q    <= 1'b0;
      overflow_q     <= 1'b0;
      protocol_err_q <= 1'b0;
      drop_count_q   <= '0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      in_flight_q    <= in_flight_d;
      out_valid_q    <= out_valid_d;
      overflow_q     <= overflow_d;
      protocol_err_q <= protocol_err_d;
      drop_count_q   <= drop_count_d;
    end
  end

  // Storage array needs no reset: the head is masked to zero while empty
  always_ff @(posedge clk) begin
    if (reset && push) mem_q[wr_ptr_q] <= res_data;
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_valid_q ? mem_q[rd_ptr_q] : '0;
  assign can_issue    = (SW'(count_q) + SW'(in_flight_q)) < SW'(DEPTH);
  assign count        = count_q;
  assign in_flight    = in_flight_q;
  assign overflow     = overflow_q;
  assign protocol_err = protocol_err_q;
  assign drop_count   = drop_count_q;

endmodule

// File: tb/tb_ffs_result_queue.sv
// Directed bench for ffs_result_queue with hand-computed expectations.
module tb_ffs_result_queue;

  logic       clk = 1'b0;
  logic       reset;
  logic       issue;
  logic       res_valid;
  logic [9:0] res_data;
  logic       out_valid;
  logic [9:0] out_data;
  logic       out_ready;
  logic       can_issue;
  logic [4:0] count;
  logic [4:0] in_flight;
  logic       overflow;
  logic       protocol_err;
  logic [7:0] drop_count;

  int n_checks = 0;
  int n_errors = 0;

  ffs_result_queue #(.WIDTH(10), .DEPTH(16), .LAT(10)) dut (
    .clk(clk), .reset(reset), .issue(issue), .res_valid(res_valid),
    .res_data(res_data), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .can_issue(can_issue), .count(count),
    .in_flight(in_flight), .overflow(overflow), .protocol_err(protocol_err),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; issue = 1'b0; res_valid = 1'b0; res_data = '0; out_ready = 1'b0;

    // 1: reset state, single round trip
    tick(); tick();
    check("rst_count", 32'(count), 0);
    check("rst_inflight", 32'(in_flight), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_can_issue", 32'(can_issue), 1);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_proto", 32'(protocol_err), 0);
    check("rst_drops", 32'(drop_count), 0);
    reset = 1'b1;
    issue = 1'b1; tick(); issue = 1'b0;
    check("t1_inflight1", 32'(in_flight), 1);
    repeat (9) tick();
    check("t1_no_bypass", 32'(out_valid), 0);
    res_valid = 1'b1; res_data = 10'd4; tick(); res_valid = 1'b0;
    check("t1_out_valid", 32'(out_valid), 1);
    check("t1_out_data", 32'(out_data), 4);
    check("t1_inflight0", 32'(in_flight), 0);
    check("t1_count1", 32'(count), 1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check("t1_count0", 32'(count), 0);
    check("t1_empty", 32'(out_valid), 0);
    check("t1_data0", 32'(out_data), 0);

    // 2: sixteen back-to-back issues exhaust credit, results fill FIFO
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t2_can_issue_%0d", i), 32'(can_issue), 1);
      issue = 1'b1; tick();
    end
    issue = 1'b0;
    check("t2_inflight16", 32'(in_flight), 16);
    check("t2_credit_gone", 32'(can_issue), 0);
    for (int i = 0; i < 16; i++) begin
      res_valid = 1'b1; res_data = 10'(i); tick();
    end
    res_valid = 1'b0;
    check("t2_count16", 32'(count), 16);
    check("t2_inflight0", 32'(in_flight), 0);
    check("t2_head", 32'(out_data), 0);
    check("t2_overflow", 32'(overflow), 0);
    check("t2_can_issue", 32'(can_issue), 0);

    // 3: push and pop together while full
    issue = 1'b1; tick(); issue = 1'b0;
    out_ready = 1'b1; res_valid = 1'b1; res_data = 10'd100; tick();
    out_ready = 1'b0; res_valid = 1'b0;
    check("t3_count", 32'(count), 16);
    check("t3_head", 32'(out_data), 1);
    check("t3_overflow", 32'(overflow), 0);
    check("t3_drops", 32'(drop_count), 0);
    check("t3_proto", 32'(protocol_err), 0);

    // 4: three results against a full, stalled FIFO are dropped
    repeat (3) begin issue = 1'b1; tick(); end
    issue = 1'b0;
    for (int i = 0; i < 3; i++) begin
      res_valid = 1'b1; res_data = 10'(200 + i); tick();
    end
    res_valid = 1'b0;
    check("t4_overflow", 32'(overflow), 1);
    check("t4_drops", 32'(drop_count), 3);
    check("t4_head", 32'(out_data), 1);
    check("t4_count", 32'(count), 16);
    check("t4_inflight", 32'(in_flight), 0);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t4_drain_%0d", i), 32'(out_data), (i < 15) ? 32'(i + 1) : 32'd100);
      tick();
    end
    out_ready = 1'b0;
    check("t4_drained", 32'(count), 0);
    check("t4_empty", 32'(out_valid), 0);

    // 5: unsolicited result
    res_valid = 1'b1; res_data = 10'd7; tick(); res_valid = 1'b0;
    check("t5_proto", 32'(protocol_err), 1);
    check("t5_count", 32'(count), 1);
    check("t5_data", 32'(out_data), 7);
    check("t5_inflight", 32'(in_flight), 0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // 6: reset mid-operation
    repeat (8) begin issue = 1'b1; tick(); end
    issue = 1'b0;
    for (int i = 0; i < 5; i++) begin
      res_valid = 1'b1; res_data = 10'(300 + i); tick();
    end
    res_valid = 1'b0;
    check("t6_pre_count", 32'(count), 5);
    check("t6_pre_inflight", 32'(in_flight), 3);
    check("t6_pre_can_issue", 32'(can_issue), 1);
    reset = 1'b0; tick(); reset = 1'b1;
    check("t6_count", 32'(count), 0);
    check("t6_inflight", 32'(in_flight), 0);
    check("t6_out_valid", 32'(out_valid), 0);
    check("t6_can_issue", 32'(can_issue), 1);
    check("t6_overflow", 32'(overflow), 0);
    check("t6_proto", 32'(protocol_err), 0);
    check("t6_drops", 32'(drop_count), 0);
    res_valid = 1'b1; res_data = 10'd9; tick(); res_valid = 1'b0;
    check("t6_late_proto", 32'(protocol_err), 1);
    check("t6_late_count", 32'(count), 1);
    check("t6_late_data", 32'(out_data), 9);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
